// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Stall/flush control bundles and the controller FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_bubble;
    logic memwb_bubble;
    logic md_start;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NOP = '0;

  localparam hz_ctrl_t CTRL_MEM_WAIT = '{
    pc_stall:     1'b1,
    ifid_stall:   1'b1,
    idex_stall:   1'b1,
    exmem_stall:  1'b1,
    memwb_bubble: 1'b1,
    default:      1'b0
  };

  localparam hz_ctrl_t CTRL_MD_ISSUE = '{
    pc_stall:     1'b1,
    ifid_stall:   1'b1,
    idex_stall:   1'b1,
    exmem_bubble: 1'b1,
    md_start:     1'b1,
    default:      1'b0
  };

  localparam hz_ctrl_t CTRL_MD_WAIT = '{
    pc_stall:     1'b1,
    ifid_stall:   1'b1,
    idex_stall:   1'b1,
    exmem_bubble: 1'b1,
    default:      1'b0
  };

  localparam hz_ctrl_t CTRL_BRANCH = '{
    ifid_flush: 1'b1,
    idex_flush: 1'b1,
    default:    1'b0
  };

  localparam hz_ctrl_t CTRL_LOAD_USE = '{
    pc_stall:   1'b1,
    ifid_stall: 1'b1,
    idex_flush: 1'b1,
    default:    1'b0
  };

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Covers load-use, branch redirect, MUL/DIV and dmem waits.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv,
  input  logic             md_done,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             md_start,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  hz_state_t st_q;
  hz_state_t st_d;
  hz_ctrl_t  ctl;
  logic      load_use;
  logic      mem_busy;

  assign mem_busy = mem_access && !dmem_ready;

  assign load_use = ex_memread && (ex_rd != REG_X0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      st_q <= RUN;
    else
      st_q <= st_d;
  end

  // next state and same-cycle stage controls
  always_comb begin
    st_d = RUN;
    ctl  = CTRL_NOP;
    case (st_q)
      RUN: begin
        if (mem_busy) begin
          ctl  = CTRL_MEM_WAIT;
          st_d = MEM_WAIT;
        end else if (ex_muldiv) begin
          ctl  = CTRL_MD_ISSUE;
          st_d = MD_WAIT;
        end else if (ex_branch_taken) begin
          ctl  = CTRL_BRANCH;
        end else if (load_use) begin
          ctl  = CTRL_LOAD_USE;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          ctl  = CTRL_MEM_WAIT;
          st_d = MEM_WAIT;
        end
      end
      MD_WAIT: begin
        if (!md_done) begin
          ctl  = CTRL_MD_WAIT;
          st_d = MD_WAIT;
        end
      end
      default: begin
        st_d = RUN;
        ctl  = CTRL_NOP;
      end
    endcase
    if (reset)
      ctl = CTRL_NOP;
  end

  assign pc_stall     = ctl.pc_stall;
  assign ifid_stall   = ctl.ifid_stall;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_stall   = ctl.idex_stall;
  assign idex_flush   = ctl.idex_flush;
  assign exmem_stall  = ctl.exmem_stall;
  assign exmem_bubble = ctl.exmem_bubble;
  assign memwb_bubble = ctl.memwb_bubble;
  assign md_start     = ctl.md_start;
  assign state        = st_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (ctl.pc_stall),
    .count(stall_cycles)
  );

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside the forwarding logic and resolves the hazards forwarding cannot cover: load-use, taken-branch redirect, the multi-cycle MUL/DIV unit, and a data memory that is not ready. It drives per-stage stall, flush and bubble controls, issues the MUL/DIV start pulse, and keeps a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of the stall_cycles performance counter

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_memread  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch or jump
ex_muldiv  in  1  EX instruction is MUL/DIV
md_done  in  1  MUL/DIV result valid this cycle
mem_access  in  1  MEM instruction is a load or store
dmem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  clear IF/ID to NOP
idex_stall  out  1  hold ID/EX register
idex_flush  out  1  load NOP into ID/EX
exmem_stall  out  1  hold EX/MEM register
exmem_bubble  out  1  load NOP into EX/MEM
memwb_bubble  out  1  load NOP into MEM/WB
md_start  out  1  one-cycle start pulse to MUL/DIV
state  out  2  FSM state (debug)
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high. While reset=1, every control output is 0, state goes to RUN and stall_cycles goes to 0.
- FSM states: RUN=0, MD_WAIT=1, MEM_WAIT=2. Code 3 is illegal and returns to RUN on the next edge.
- All control outputs are combinational from the state and the current inputs, so they act in the same cycle.
- RUN priority, highest first:
  1. Memory wait: mem_access && !dmem_ready. pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble are 1. Next state is MEM_WAIT.
  2. MUL/DIV: ex_muldiv. md_start, pc_stall, ifid_stall, idex_stall and exmem_bubble are 1. Next state is MD_WAIT.
  3. Taken branch: ex_branch_taken. ifid_flush and idex_flush are 1, pc_stall is 0. Any load-use on the flushed ID instruction is ignored.
  4. Load-use: ex_memread && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). pc_stall, ifid_stall and idex_flush are 1. This is a single-cycle bubble with no state change.
- MEM_WAIT: the RUN-1 outputs hold until dmem_ready=1. In that cycle all outputs are 0 and the next state is RUN. A pending branch or MUL/DIV in EX is re-evaluated in RUN afterwards.
- MD_WAIT:
  - md_start=0 here. It pulses exactly once per MUL/DIV instruction.
  - While md_done=0: pc_stall, ifid_stall, idex_stall and exmem_bubble are 1.
  - When md_done=1: all outputs are 0, the EX instruction advances with its result, and the next state is RUN.
  - Minimum occupancy is 2 cycles (RUN issue cycle, then MD_WAIT).
  - md_done is ignored outside MD_WAIT.
- Register x0 never causes a load-use stall.
- A MUL/DIV issue in the cycle right after MD_WAIT is legal. It pulses md_start again.
- stall_cycles increments on each edge where pc_stall=1 and reset=0, and saturates at all-ones.
- Reset mid-operation (MD_WAIT or MEM_WAIT): return to RUN with no md_start re-issue. The MUL/DIV unit shares the same reset.

Decomposition:
- hazard_pkg holds:
  - the hz_state_t enum (RUN, MD_WAIT, MEM_WAIT);
  - the constant REG_X0 = 5'd0;
  - the NOP-control encodings shared with the pipeline registers.
- One sub-module, sat_counter (parameter W, with inc and sync reset), implements stall_cycles.

Test Plan:
- Load-use: EX lw x5 (ex_memread=1, ex_rd=5); ID add with id_rs2=5 and id_uses_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0; stall_cycles=1.
- x0 and unused-operand filter: ex_rd=0 with ex_memread=1 and id_rs1=0 -> no stall. ex_rd=7 with id_rs1=7 but id_uses_rs1=0 -> no stall.
- Branch beats load-use: ex_branch_taken=1 together with a load-use match -> ifid_flush=idex_flush=1, pc_stall=0, state stays RUN.
- MUL/DIV, 4-cycle unit: ex_muldiv=1, with md_done arriving 3 cycles after issue -> md_start high for exactly 1 cycle; pc_stall high for 3 cycles; state RUN->MD_WAIT->RUN; stall_cycles=3.
- Memory wait beats MUL/DIV: mem_access=1, dmem_ready=0 for 2 cycles while ex_muldiv=1 -> exmem_stall and memwb_bubble high for 2 cycles and md_start=0. When dmem_ready=1, the next cycle issues md_start.
- Reset mid-MD_WAIT: assert reset for 1 cycle -> state=RUN, all outputs 0, stall_cycles=0. No md_start until a new ex_muldiv arrives. Counter saturation with CNT_W=2: after 5 stalled cycles, stall_cycles=3.
